picorv32_mem_responder: RTL and testbench

// - Memory-side responder for the picorv32 native bus in formal/sim harnesses. It sits directly

---
 rtl/picorv32_mem_pkg.sv | 19 +
 rtl/mem_byte_ram.sv | 27 ++
 rtl/picorv32_mem_responder.sv | 125 ++++++++++++
 tb/tb_picorv32_mem_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_mem_pkg.sv
// Shared types and constants for the picorv32 memory responder.
package picorv32_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int ERR_UNSTABLE = 0;
   localparam int ERR_ABORT    = 1;
   localparam int ERR_TIMEOUT  = 2;

   // Requested wait states above the ceiling are silently clamped.
   function automatic logic [3:0] clamp_wait(input logic [3:0] sel, input logic [3:0] max_wait);
      return (sel > max_wait) ? max_wait : sel;
   endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Word-organised RAM with per-byte write enables and a combinational read port.
module mem_byte_ram #(
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [3:0]           be,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [31:0]          wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [31:0]          rdata
);

   logic [31:0] mem [2**ADDR_BITS];

   // Byte-masked write; contents are intentionally never reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/picorv32_mem_responder.sv
// Memory-side responder for the picorv32 native bus: programmable wait states,
// byte-writable backing RAM and sticky protocol-violation flags.
//
// state | meaning
// IDLE  | waiting for mem_valid; request fields latched on accept
// WAIT  | counting down wait states, watching for abort/instability
// RESP  | mem_ready pulse; write committed at the end of this cycle
module picorv32_mem_responder
   import picorv32_mem_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int MAX_WAIT  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   input  logic [3:0]  wait_sel,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        busy,
   output logic [2:0]  err
);

   localparam logic [3:0] WAIT_CEIL  = 4'(MAX_WAIT);
   localparam logic [4:0] GUARD_LIMIT = 5'(MAX_WAIT + 1);

   state_t               state;
   logic [3:0]           wcnt;
   logic [4:0]           guard;
   logic [31:0]          addr_q;
   logic [31:0]          wdata_q;
   logic [3:0]           wstrb_q;
   logic                 instr_q;
   logic [ADDR_BITS-1:0] word_idx;
   logic [31:0]          ram_rdata;
   logic                 ram_we;
   logic                 unstable;
   logic                 abort_now;
   logic                 timeout_now;

   assign word_idx = addr_q[ADDR_BITS+1:2];

   // Write lands on the RESP edge only; a reset in that cycle cancels it.
   assign ram_we = (state == RESP) && (wstrb_q != 4'h0) && !reset;

   assign unstable = (state != IDLE) && mem_valid &&
                     ((mem_addr != addr_q) || (mem_wdata != wdata_q) ||
                      (mem_wstrb != wstrb_q) || (mem_instr != instr_q));
   assign abort_now   = (state == WAIT) && !mem_valid;
   assign timeout_now = (state != IDLE) && (guard > GUARD_LIMIT);

   mem_byte_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .be    (wstrb_q),
      .waddr (word_idx),
      .wdata (wdata_q),
      .raddr (word_idx),
      .rdata (ram_rdata)
   );

   // Transaction FSM with registered bus outputs and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wcnt      <= 4'd0;
         guard     <= 5'd0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'h0;
         instr_q   <= 1'b0;
         mem_ready <= 1'b0;
         mem_rdata <= 32'h0;
         busy      <= 1'b0;
         err       <= 3'b000;
      end else begin
         mem_ready <= 1'b0;
         mem_rdata <= 32'h0;
         if (unstable)    err[ERR_UNSTABLE] <= 1'b1;
         if (abort_now)   err[ERR_ABORT]    <= 1'b1;
         if (timeout_now) err[ERR_TIMEOUT]  <= 1'b1;
         case (state)
            IDLE: begin
               guard <= 5'd0;
               if (mem_valid) begin
                  addr_q  <= mem_addr;
                  wdata_q <= mem_wdata;
                  wstrb_q <= mem_wstrb;
                  instr_q <= mem_instr;
                  wcnt    <= clamp_wait(wait_sel, WAIT_CEIL);
                  state   <= WAIT;
                  busy    <= 1'b1;
               end
            end
            WAIT: begin
               guard <= guard + 5'd1;
               if (!mem_valid) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (wcnt == 4'd0) begin
                  state     <= RESP;
                  mem_ready <= 1'b1;
                  mem_rdata <= (wstrb_q == 4'h0) ? ram_rdata : 32'h0;
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
               guard <= 5'd0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Directed bench for picorv32_mem_responder (ADDR_BITS=8, MAX_WAIT=4).
module tb_picorv32_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [3:0]  wait_sel;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        busy;
   logic [2:0]  err;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] rd;
   int          lat;
   int          n;
   logic        seen;

   picorv32_mem_responder #(.ADDR_BITS(8), .MAX_WAIT(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_valid (mem_valid),
      .mem_instr (mem_instr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .wait_sel  (wait_sel),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction; lat = edges from accept edge to mem_ready high.
   task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [3:0] w, output logic [31:0] rdata_o, output int lat_o);
      int   cnt;
      logic got;
      cnt = 0;
      got = 1'b0;
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = d;
      mem_wstrb = s;
      wait_sel  = w;
      mem_instr = 1'b0;
      step();
      while (!got && cnt < 20) begin
         step();
         cnt++;
         if (mem_ready === 1'b1) got = 1'b1;
      end
      check("ready_seen", {31'h0, got}, 32'h1);
      rdata_o = mem_rdata;
      lat_o   = cnt;
      mem_valid = 1'b0;
      step();
      check("idle_ready", {31'h0, mem_ready}, 32'h0);
      check("idle_rdata", mem_rdata, 32'h0);
      check("idle_busy", {31'h0, busy}, 32'h0);
   endtask

   initial begin
      reset     = 1'b1;
      mem_valid = 1'b0;
      mem_instr = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      mem_wstrb = 4'h0;
      wait_sel  = 4'h0;
      repeat (3) step();
      check("rst_ready", {31'h0, mem_ready}, 32'h0);
      check("rst_rdata", mem_rdata, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_err", {29'h0, err}, 32'h0);
      reset = 1'b0;
      step();

      // Preload RAM[4], RAM[8], RAM[16], RAM[17] with full-word writes.
      txn(32'h10, 32'hDEADBEEF, 4'hF, 4'd0, rd, lat);
      check("wr_rdata_zero", rd, 32'h0);
      check("wr_lat0", lat, 1);
      txn(32'h20, 32'hAABBCCDD, 4'hF, 4'd1, rd, lat);
      txn(32'h40, 32'h0BADF00D, 4'hF, 4'd0, rd, lat);
      txn(32'h44, 32'h12345678, 4'hF, 4'd0, rd, lat);

      // Read with zero wait states.
      txn(32'h10, 32'h0, 4'h0, 4'd0, rd, lat);
      check("rd0_data", rd, 32'hDEADBEEF);
      check("rd0_lat", lat, 1);

      // Partial write via byte strobes, then read back.
      txn(32'h20, 32'h11223344, 4'b0101, 4'd0, rd, lat);
      txn(32'h20, 32'h0, 4'h0, 4'd2, rd, lat);
      check("bytewr_data", rd, 32'hAA22CC44);
      check("lat_w2", lat, 3);

      // Clamp: 9 -> 4 wait states, exactly at the ceiling too.
      txn(32'h10, 32'h0, 4'h0, 4'd9, rd, lat);
      check("clamp9_lat", lat, 5);
      check("clamp9_data", rd, 32'hDEADBEEF);
      check("clamp9_err", {29'h0, err}, 32'h0);
      txn(32'h40, 32'h0, 4'h0, 4'd4, rd, lat);
      check("w4_lat", lat, 5);
      check("w4_data", rd, 32'h0BADF00D);

      // Address aliasing: 0x410 maps to word 4.
      txn(32'h410, 32'h0, 4'h0, 4'd1, rd, lat);
      check("alias_data", rd, 32'hDEADBEEF);
      check("alias_err", {29'h0, err}, 32'h0);

      // Abort: write to 0x20, valid dropped in the second WAIT cycle.
      mem_valid = 1'b1;
      mem_addr  = 32'h20;
      mem_wdata = 32'h55667788;
      mem_wstrb = 4'hF;
      wait_sel  = 4'd3;
      step();
      check("abort_busy_w1", {31'h0, busy}, 32'h1);
      step();
      mem_valid = 1'b0;
      step();
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_ready", {31'h0, mem_ready}, 32'h0);
      check("abort_err", {29'h0, err}, 32'h2);
      seen = 1'b0;
      repeat (5) begin
         step();
         if (mem_ready === 1'b1) seen = 1'b1;
      end
      check("abort_no_ready", {31'h0, seen}, 32'h0);
      txn(32'h20, 32'h0, 4'h0, 4'd0, rd, lat);
      check("abort_ram_kept", rd, 32'hAA22CC44);
      check("abort_err_sticky", {29'h0, err}, 32'h2);

      reset = 1'b1;
      step();
      reset = 1'b0;
      check("err_cleared", {29'h0, err}, 32'h0);
      step();

      // Unstable address during WAIT: latched address still used.
      mem_valid = 1'b1;
      mem_addr  = 32'h40;
      mem_wdata = 32'h0;
      mem_wstrb = 4'h0;
      wait_sel  = 4'd2;
      step();
      mem_addr = 32'h44;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         step();
         n++;
         if (mem_ready === 1'b1) seen = 1'b1;
      end
      check("unst_ready_seen", {31'h0, seen}, 32'h1);
      check("unst_lat", n, 3);
      check("unst_rdata", mem_rdata, 32'h0BADF00D);
      check("unst_err", {29'h0, err}, 32'h1);
      mem_valid = 1'b0;
      step();

      // Reset in the WAIT cycle of a write: nothing committed.
      mem_valid = 1'b1;
      mem_addr  = 32'h40;
      mem_wdata = 32'hFFFFFFFF;
      mem_wstrb = 4'hF;
      wait_sel  = 4'd3;
      step();
      reset = 1'b1;
      step();
      check("rstw_ready", {31'h0, mem_ready}, 32'h0);
      check("rstw_busy", {31'h0, busy}, 32'h0);
      check("rstw_err", {29'h0, err}, 32'h0);
      reset     = 1'b0;
      mem_valid = 1'b0;
      step();
      txn(32'h40, 32'h0, 4'h0, 4'd0, rd, lat);
      check("rstw_ram_kept", rd, 32'h0BADF00D);

      // Reset on the RESP edge of a zero-wait write also cancels it.
      mem_valid = 1'b1;
      mem_addr  = 32'h44;
      mem_wdata = 32'hCAFEF00D;
      mem_wstrb = 4'hF;
      wait_sel  = 4'd0;
      step();
      step();
      check("rsp_ready", {31'h0, mem_ready}, 32'h1);
      reset = 1'b1;
      step();
      reset     = 1'b0;
      mem_valid = 1'b0;
      step();
      txn(32'h44, 32'h0, 4'h0, 4'd0, rd, lat);
      check("rsp_ram_kept", rd, 32'h12345678);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
